// File: rtl/rename_pkg.sv
// rtl/rename_pkg.sv - shared widths, uop/commit records and the x0 source helper for the rename stage
package rename_pkg;

    localparam int ARCH_REGS      = 32;
    localparam int LOG_ARCH_REGS  = 5;
    localparam int NUM_PREGS      = 64;
    localparam int PREG_IDX_WIDTH = 6;
    localparam int ARCH_IDX_W     = LOG_ARCH_REGS;
    localparam int PREG_IDX_W     = PREG_IDX_WIDTH;
    localparam int AVAIL_W        = $clog2(NUM_PREGS + 1);

    typedef logic [ARCH_IDX_W-1:0] arch_idx_t;
    typedef logic [PREG_IDX_W-1:0] preg_t;

    typedef struct packed {
        logic  valid;
        preg_t prs1;
        preg_t prs2;
        preg_t prd;
        preg_t old_prd;
    } rename_uop_t;

    typedef struct packed {
        logic      valid;
        arch_idx_t rd;
        preg_t     prd;
    } commit_t;

    // With x0 hardwired, reading arch 0 always yields physical 0.
    function automatic preg_t src_preg(input logic x0_hard, input arch_idx_t a, input preg_t m);
        return (x0_hard && (a == '0)) ? '0 : m;
    endfunction

endpackage

// File: rtl/rat_bank.sv
// rtl/rat_bank.sv - register alias table: identity reset, N comb reads, 2 writes (port1 wins), bulk load
module rat_bank
    import rename_pkg::*;
#(
    parameter int N_RD = 2
) (
    input  logic                             clock_i,
    input  logic                             reset_i,
    input  logic                             load_i,
    input  logic [ARCH_REGS*PREG_IDX_W-1:0]  load_data_i,
    input  logic                             we0_i,
    input  logic [ARCH_IDX_W-1:0]            wa0_i,
    input  logic [PREG_IDX_W-1:0]            wd0_i,
    input  logic                             we1_i,
    input  logic [ARCH_IDX_W-1:0]            wa1_i,
    input  logic [PREG_IDX_W-1:0]            wd1_i,
    input  logic [N_RD*ARCH_IDX_W-1:0]       rd_addr_i,
    output logic [N_RD*PREG_IDX_W-1:0]       rd_data_o,
    output logic [ARCH_REGS*PREG_IDX_W-1:0]  next_o
);

    preg_t map_q [ARCH_REGS];
    preg_t map_d [ARCH_REGS];

    always_comb begin
        map_d = map_q;
        if (load_i) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                map_d[i] = load_data_i[i*PREG_IDX_W +: PREG_IDX_W];
            end
        end else begin
            if (we0_i) map_d[wa0_i] = wd0_i;
            if (we1_i) map_d[wa1_i] = wd1_i;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                map_q[i] <= PREG_IDX_W'(i);
            end
        end else begin
            map_q <= map_d;
        end
    end

    always_comb begin
        for (int r = 0; r < N_RD; r++) begin
            rd_data_o[r*PREG_IDX_W +: PREG_IDX_W] = map_q[rd_addr_i[r*ARCH_IDX_W +: ARCH_IDX_W]];
        end
    end

    // Post-write image lets a flush copy arch with this cycle's commits already applied.
    always_comb begin
        for (int i = 0; i < ARCH_REGS; i++) begin
            next_o[i*PREG_IDX_W +: PREG_IDX_W] = map_d[i];
        end
    end

endmodule

// File: rtl/rename_map.sv
// rtl/rename_map.sv - 2-wide rename stage with spec/arch RATs; macro RENAME_X0_EN hardwires arch x0
module rename_map
    import rename_pkg::*;
(
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  flush_i,
    input  logic                  in0_valid_i,
    input  logic [ARCH_IDX_W-1:0] in0_rs1_i,
    input  logic [ARCH_IDX_W-1:0] in0_rs2_i,
    input  logic [ARCH_IDX_W-1:0] in0_rd_i,
    input  logic                  in0_rd_wen_i,
    input  logic                  in1_valid_i,
    input  logic [ARCH_IDX_W-1:0] in1_rs1_i,
    input  logic [ARCH_IDX_W-1:0] in1_rs2_i,
    input  logic [ARCH_IDX_W-1:0] in1_rd_i,
    input  logic                  in1_rd_wen_i,
    output logic                  in_ready_o,
    input  logic [AVAIL_W-1:0]    fl_avail_i,
    output logic                  fl_req0_valid_o,
    output logic                  fl_req1_valid_o,
    input  logic [PREG_IDX_W-1:0] fl_req0_data_i,
    input  logic [PREG_IDX_W-1:0] fl_req1_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  out0_valid_o,
    output logic [PREG_IDX_W-1:0] out0_prs1_o,
    output logic [PREG_IDX_W-1:0] out0_prs2_o,
    output logic [PREG_IDX_W-1:0] out0_prd_o,
    output logic [PREG_IDX_W-1:0] out0_old_prd_o,
    output logic                  out1_valid_o,
    output logic [PREG_IDX_W-1:0] out1_prs1_o,
    output logic [PREG_IDX_W-1:0] out1_prs2_o,
    output logic [PREG_IDX_W-1:0] out1_prd_o,
    output logic [PREG_IDX_W-1:0] out1_old_prd_o,
    input  logic                  commit0_valid_i,
    input  logic [ARCH_IDX_W-1:0] commit0_rd_i,
    input  logic [PREG_IDX_W-1:0] commit0_prd_i,
    input  logic                  commit1_valid_i,
    input  logic [ARCH_IDX_W-1:0] commit1_rd_i,
    input  logic [PREG_IDX_W-1:0] commit1_prd_i,
    output logic                  fl_free0_valid_o,
    output logic [PREG_IDX_W-1:0] fl_free0_data_o,
    output logic                  fl_free1_valid_o,
    output logic [PREG_IDX_W-1:0] fl_free1_data_o
);

`ifdef RENAME_X0_EN
    localparam logic X0_HARD = 1'b1;
`else
    localparam logic X0_HARD = 1'b0;
`endif

    logic        need0, need1, fire, out_valid_q;
    logic [1:0]  need;
    preg_t       prd0, prd1;
    rename_uop_t uop0_d, uop1_d, out0_q, out1_q;
    commit_t     c0, c1;
    logic [6*PREG_IDX_W-1:0]         spec_rdata;
    logic [2*PREG_IDX_W-1:0]         arch_rdata;
    logic [ARCH_REGS*PREG_IDX_W-1:0] arch_next;

    assign need0 = in0_valid_i && in0_rd_wen_i && !(X0_HARD && (in0_rd_i == '0));
    assign need1 = in1_valid_i && in1_rd_wen_i && !(X0_HARD && (in1_rd_i == '0));
    assign need  = {1'b0, need0} + {1'b0, need1};

    assign in_ready_o = !flush_i && (!out_valid_q || out_ready_i) && (fl_avail_i >= AVAIL_W'(need));
    assign fire       = in0_valid_i && in_ready_o;

    // Allocation is compacted: the first slot that needs a preg always takes the freelist head.
    assign fl_req0_valid_o = fire && (need0 || need1);
    assign fl_req1_valid_o = fire && need0 && need1;
    assign prd0 = need0 ? fl_req0_data_i : '0;
    assign prd1 = !need1 ? '0 : (need0 ? fl_req1_data_i : fl_req0_data_i);

    rat_bank #(.N_RD(6)) u_spec (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .load_i      (flush_i),
        .load_data_i (arch_next),
        .we0_i       (fire && need0),
        .wa0_i       (in0_rd_i),
        .wd0_i       (prd0),
        .we1_i       (fire && need1),
        .wa1_i       (in1_rd_i),
        .wd1_i       (prd1),
        .rd_addr_i   ({in1_rd_i, in1_rs2_i, in1_rs1_i, in0_rd_i, in0_rs2_i, in0_rs1_i}),
        .rd_data_o   (spec_rdata),
        .next_o      ()
    );

    // Slot 1 sees slot 0's new mapping as if the pair were renamed in order.
    always_comb begin
        uop0_d.valid   = in0_valid_i;
        uop0_d.prs1    = src_preg(X0_HARD, in0_rs1_i, spec_rdata[0*PREG_IDX_W +: PREG_IDX_W]);
        uop0_d.prs2    = src_preg(X0_HARD, in0_rs2_i, spec_rdata[1*PREG_IDX_W +: PREG_IDX_W]);
        uop0_d.prd     = prd0;
        uop0_d.old_prd = spec_rdata[2*PREG_IDX_W +: PREG_IDX_W];
        uop1_d.valid   = in1_valid_i;
        uop1_d.prs1    = (need0 && in1_rs1_i == in0_rd_i) ? prd0 :
                         src_preg(X0_HARD, in1_rs1_i, spec_rdata[3*PREG_IDX_W +: PREG_IDX_W]);
        uop1_d.prs2    = (need0 && in1_rs2_i == in0_rd_i) ? prd0 :
                         src_preg(X0_HARD, in1_rs2_i, spec_rdata[4*PREG_IDX_W +: PREG_IDX_W]);
        uop1_d.prd     = prd1;
        uop1_d.old_prd = (need0 && in1_rd_i == in0_rd_i) ? prd0 : spec_rdata[5*PREG_IDX_W +: PREG_IDX_W];
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            out_valid_q <= 1'b0;
            out0_q      <= '0;
            out1_q      <= '0;
        end else if (fire) begin
            out_valid_q <= 1'b1;
            out0_q      <= uop0_d;
            out1_q      <= uop1_d;
        end else if (out_ready_i || flush_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid_o    = out_valid_q;
    assign out0_valid_o   = out0_q.valid;
    assign out0_prs1_o    = out0_q.prs1;
    assign out0_prs2_o    = out0_q.prs2;
    assign out0_prd_o     = out0_q.prd;
    assign out0_old_prd_o = out0_q.old_prd;
    assign out1_valid_o   = out1_q.valid;
    assign out1_prs1_o    = out1_q.prs1;
    assign out1_prs2_o    = out1_q.prs2;
    assign out1_prd_o     = out1_q.prd;
    assign out1_old_prd_o = out1_q.old_prd;

    assign c0 = '{valid: commit0_valid_i && !(X0_HARD && (commit0_rd_i == '0)), rd: commit0_rd_i, prd: commit0_prd_i};
    assign c1 = '{valid: commit1_valid_i && !(X0_HARD && (commit1_rd_i == '0)), rd: commit1_rd_i, prd: commit1_prd_i};

    rat_bank #(.N_RD(2)) u_arch (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .load_i      (1'b0),
        .load_data_i ('0),
        .we0_i       (c0.valid),
        .wa0_i       (c0.rd),
        .wd0_i       (c0.prd),
        .we1_i       (c1.valid),
        .wa1_i       (c1.rd),
        .wd1_i       (c1.prd),
        .rd_addr_i   ({c1.rd, c0.rd}),
        .rd_data_o   (arch_rdata),
        .next_o      (arch_next)
    );

    // A younger commit to the same rd frees the preg the older commit just installed.
    assign fl_free0_valid_o = c0.valid;
    assign fl_free0_data_o  = arch_rdata[0 +: PREG_IDX_W];
    assign fl_free1_valid_o = c1.valid;
    assign fl_free1_data_o  = (c0.valid && c1.rd == c0.rd) ? c0.prd : arch_rdata[PREG_IDX_W +: PREG_IDX_W];

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            assert (!(in1_valid_i && !in0_valid_i));
        end
    end

endmodule
